// File: rtl/clk_recover_set_counter.sv
// Bit-clock recovery for an oversampled serial line: a phase counter re-aligned
// on every rx transition produces a one-cycle strobe at each recovered bit centre.
module clk_recover_set_counter #(
  parameter int unsigned TARGET_PERIOD = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic rx,
  output logic clkStrobe,
  output logic rxClocked
);

  localparam int unsigned HALF = TARGET_PERIOD / 2;
  localparam int unsigned CW   = $clog2(TARGET_PERIOD);

  localparam logic [CW-1:0] COUNT_LAST = CW'(TARGET_PERIOD - 1);
  localparam logic [CW-1:0] COUNT_HALF = CW'(HALF);

  logic          rxSync1;
  logic          rxSync;
  logic          rxPrev;
  logic          rxEdge;
  logic [CW-1:0] counter;

  always_comb begin
    rxEdge = rxSync ^ rxPrev;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rxSync1   <= 1'b0;
      rxSync    <= 1'b0;
      rxPrev    <= 1'b0;
      counter   <= '0;
      clkStrobe <= 1'b0;
      rxClocked <= 1'b0;
    end else begin
      rxSync1 <= rx;
      rxSync  <= rxSync1;
      rxPrev  <= rxSync;

      // A transition re-phases the counter and wins over a coincident bit centre.
      if (rxEdge) begin
        counter <= '0;
      end else if (counter == COUNT_LAST) begin
        counter <= '0;
      end else begin
        counter <= counter + 1'b1;
      end

      if (!rxEdge && counter == COUNT_HALF) begin
        clkStrobe <= 1'b1;
        rxClocked <= rxSync;
      end else begin
        clkStrobe <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_clk_recover_set_counter.sv
// Directed bench for clk_recover_set_counter (TARGET_PERIOD = 10) plus an
// 8b10b-coded random byte stream checked bit-for-bit at the recovered strobes.
module tb_clk_recover_set_counter;

  logic clk = 1'b0;
  logic rst;
  logic rx;
  logic clkStrobe;
  logic rxClocked;

  int passed = 0;
  int total  = 0;
  logic rdState = 1'b0;
  logic seqQ[$];

  clk_recover_set_counter #(.TARGET_PERIOD(10)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .clkStrobe (clkStrobe),
    .rxClocked (rxClocked)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [5:0] tab6(input logic [4:0] x);
    case (x)
      5'd0:  tab6 = 6'b100111;  5'd1:  tab6 = 6'b011101;
      5'd2:  tab6 = 6'b101101;  5'd3:  tab6 = 6'b110001;
      5'd4:  tab6 = 6'b110101;  5'd5:  tab6 = 6'b101001;
      5'd6:  tab6 = 6'b011001;  5'd7:  tab6 = 6'b111000;
      5'd8:  tab6 = 6'b111001;  5'd9:  tab6 = 6'b100101;
      5'd10: tab6 = 6'b010101;  5'd11: tab6 = 6'b110100;
      5'd12: tab6 = 6'b001101;  5'd13: tab6 = 6'b101100;
      5'd14: tab6 = 6'b011100;  5'd15: tab6 = 6'b010111;
      5'd16: tab6 = 6'b011011;  5'd17: tab6 = 6'b100011;
      5'd18: tab6 = 6'b010011;  5'd19: tab6 = 6'b110010;
      5'd20: tab6 = 6'b001011;  5'd21: tab6 = 6'b101010;
      5'd22: tab6 = 6'b011010;  5'd23: tab6 = 6'b111010;
      5'd24: tab6 = 6'b110011;  5'd25: tab6 = 6'b100110;
      5'd26: tab6 = 6'b010110;  5'd27: tab6 = 6'b110110;
      5'd28: tab6 = 6'b001110;  5'd29: tab6 = 6'b101110;
      5'd30: tab6 = 6'b011110;  default: tab6 = 6'b101011;
    endcase
  endfunction

  // rdState = 0 means running disparity negative; table entries are the RD- forms.
  function automatic logic [9:0] enc8b10b(input logic [7:0] d);
    logic [5:0] c6;
    logic [3:0] c4;
    logic       alt;
    logic [4:0] x;
    x  = d[4:0];
    c6 = tab6(x);
    if ($countones(c6) != 3) begin
      if (rdState) c6 = ~c6;
      rdState = ~rdState;
    end else if (x == 5'd7 && rdState) begin
      c6 = 6'b000111;
    end
    alt = rdState ? (x == 5'd11 || x == 5'd13 || x == 5'd14)
                  : (x == 5'd17 || x == 5'd18 || x == 5'd20);
    case (d[7:5])
      3'd0: c4 = 4'b1011;
      3'd1: c4 = 4'b1001;
      3'd2: c4 = 4'b0101;
      3'd3: c4 = 4'b1100;
      3'd4: c4 = 4'b1101;
      3'd5: c4 = 4'b1010;
      3'd6: c4 = 4'b0110;
      default: c4 = alt ? 4'b0111 : 4'b1110;
    endcase
    if ($countones(c4) != 2) begin
      if (rdState) c4 = ~c4;
      rdState = ~rdState;
    end else if (d[7:5] == 3'd3 && rdState) begin
      c4 = 4'b0011;
    end
    return {c6, c4};
  endfunction

  task automatic loadPat(input logic [31:0] pat, input int n);
    seqQ.delete();
    for (int i = n - 1; i >= 0; i--) seqQ.push_back(pat[i]);
  endtask

  // Lead bit forces a transition into bit 0; a terminator transition closes the
  // run. Strobes from the first two cycles still belong to the lead bit.
  task automatic sendQ(input logic bits[$], input int per, input string tag);
    logic got[$];
    int   n;
    int   t;
    int   dbl;
    logic prevS;
    n = bits.size();
    t = 0;
    dbl = 0;
    prevS = 1'b0;
    rx = ~bits[0];
    repeat (per) step();
    for (int i = 0; i <= n; i++) begin
      rx = (i < n) ? bits[i] : ~bits[n-1];
      for (int c = 0; c < per; c++) begin
        step();
        if (clkStrobe && prevS) dbl++;
        prevS = clkStrobe;
        if (t >= 2 && clkStrobe) got.push_back(rxClocked);
        t++;
        if (i == n && c == 1) break;
      end
    end
    chk({tag, "_count"}, 32'(got.size()), 32'(n));
    chk({tag, "_double"}, 32'(dbl), 32'd0);
    for (int i = 0; i < n && i < got.size(); i++)
      chk($sformatf("%s[%0d]", tag, i), 32'(got[i]), 32'(bits[i]));
  endtask

  initial begin
    rst = 1'b1;
    rx  = 1'b0;

    // Reset state
    repeat (3) step();
    chk("rst_strobe", 32'(clkStrobe), 32'd0);
    chk("rst_rxClocked", 32'(rxClocked), 32'd0);
    chk("rst_counter", 32'(dut.counter), 32'd0);

    // rx held low: counter free-runs from 0, strobe after edge 5 then every 10
    rst = 1'b0;
    for (int j = 0; j < 40; j++) begin
      step();
      chk($sformatf("free_strobe%0d", j), 32'(clkStrobe), 32'(j % 10 == 5));
      chk($sformatf("free_rxc%0d", j), 32'(rxClocked), 32'd0);
    end

    // Single 0->1 step: counter 0 after E0+2, strobe after E0+8 and E0+18
    rx = 1'b1;
    for (int m = 0; m < 26; m++) begin
      step();
      if (m == 2) chk("step_counter", 32'(dut.counter), 32'd0);
      chk($sformatf("step_strobe%0d", m), 32'(clkStrobe), 32'(m == 8 || m == 18));
      chk($sformatf("step_rxc%0d", m), 32'(rxClocked), 32'(m >= 8));
    end

    // Edge arrives exactly when counter == HALF: edge wins, strobe 6 cycles later
    rx = 1'b0;
    for (int q = 0; q < 10; q++) begin
      step();
      if (q == 1) chk("coll_half", 32'(dut.counter), 32'd5);
      if (q == 2) chk("coll_counter", 32'(dut.counter), 32'd0);
      chk($sformatf("coll_strobe%0d", q), 32'(clkStrobe), 32'(q == 8));
      chk($sformatf("coll_rxc%0d", q), 32'(rxClocked), 32'(q < 8));
    end

    // Alternating pattern at the nominal period
    loadPat(32'b1010101010, 10);
    sendQ(seqQ, 10, "alt10");

    // Slow and fast senders (runs limited to 3 at period 9, up to 5 at 11)
    loadPat(32'b1110010001101101, 16);
    sendQ(seqQ, 9, "per9");
    loadPat(32'b1111100000100111, 16);
    sendQ(seqQ, 11, "per11");

    // One-cycle reset mid-stream with rx high, then relock on the post-reset edge
    chk("prerst_rxc", 32'(rxClocked), 32'd1);
    rx  = 1'b1;
    rst = 1'b1;
    step();
    chk("mid_rst_strobe", 32'(clkStrobe), 32'd0);
    chk("mid_rst_rxc", 32'(rxClocked), 32'd0);
    chk("mid_rst_counter", 32'(dut.counter), 32'd0);
    chk("mid_rst_sync1", 32'(dut.rxSync1), 32'd0);
    rst = 1'b0;
    for (int j = 0; j < 10; j++) begin
      step();
      chk($sformatf("relock_strobe%0d", j), 32'(clkStrobe), 32'(j == 8));
      chk($sformatf("relock_rxc%0d", j), 32'(rxClocked), 32'(j >= 8));
    end

    // System test: random bytes through an 8b10b serialiser at 10 clocks per bit
    seqQ.delete();
    for (int b = 0; b < 400; b++) begin
      logic [9:0] code;
      code = enc8b10b(8'($urandom_range(0, 255)));
      for (int k = 9; k >= 0; k--) seqQ.push_back(code[k]);
    end
    sendQ(seqQ, 10, "sys8b10b");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
